// File: rtl/countdown_delay_meter_if.sv
// Result channel of countdown_delay_meter: measured delay plus
// overflow flag, transferred on a valid/ready handshake.
interface countdown_delay_meter_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] m_data;
  logic             m_overflow;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output m_data,
    output m_overflow,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_overflow,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/countdown_delay_meter.sv
// Counts sys_clk cycles between a start_in edge and the matching stop_in edge.
// Define DELAY_METER_AVG_EN to report the mean of 2^AVG_LOG2 measurements.
module countdown_delay_meter #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic arm,
  input  logic start_in,
  input  logic stop_in,
  output logic busy,
  countdown_delay_meter_if.master m
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] start_sync;
  logic [SYNC_STAGES-1:0] stop_sync;
  logic start_prev;
  logic stop_prev;
  logic start_edge;
  logic stop_edge;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;

  logic             meas_done;
  logic [WIDTH-1:0] meas_val;
  logic             meas_ovf;
  logic             last_sub;
  logic [WIDTH-1:0] fin_data;
  logic             fin_ovf;

  // Identical paths on both lines so their latency cancels
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      start_sync <= '0;
      stop_sync  <= '0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_in};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop_in};
      start_prev <= start_sync[SYNC_STAGES-1];
      stop_prev  <= stop_sync[SYNC_STAGES-1];
    end
  end

  assign start_edge = start_sync[SYNC_STAGES-1] ^ start_prev;
  assign stop_edge  = stop_sync[SYNC_STAGES-1] ^ stop_prev;

  // Saturation wins over a coincident stop edge
  always_comb begin
    meas_done = 1'b0;
    meas_val  = '0;
    meas_ovf  = 1'b0;
    unique case (state)
      ARMED: begin
        if (start_edge && stop_edge) begin
          meas_done = 1'b1;
        end
      end
      COUNT: begin
        if (cnt == MAX) begin
          meas_done = 1'b1;
          meas_val  = MAX;
          meas_ovf  = 1'b1;
        end else if (stop_edge) begin
          meas_done = 1'b1;
          meas_val  = cnt;
        end
      end
      default: ;
    endcase
  end

`ifdef DELAY_METER_AVG_EN
  localparam int SW = WIDTH + AVG_LOG2;

  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_nx;
  logic                ovf_acc_q;
  logic                ovf_any;
  logic [AVG_LOG2-1:0] sub_q;

  assign sum_nx   = sum_q + SW'(meas_val);
  assign ovf_any  = ovf_acc_q | meas_ovf;
  assign last_sub = &sub_q;
  assign fin_ovf  = ovf_any;
  assign fin_data = ovf_any ? MAX : sum_nx[SW-1:AVG_LOG2];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sum_q     <= '0;
      ovf_acc_q <= 1'b0;
      sub_q     <= '0;
    end else if (meas_done) begin
      if (last_sub) begin
        sum_q     <= '0;
        ovf_acc_q <= 1'b0;
        sub_q     <= '0;
      end else begin
        sum_q     <= sum_nx;
        ovf_acc_q <= ovf_any;
        sub_q     <= sub_q + AVG_LOG2'(1);
      end
    end
  end
`else
  assign last_sub = 1'b1;
  assign fin_data = meas_val;
  assign fin_ovf  = meas_ovf;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (arm) state_nx = ARMED;
      end
      ARMED: begin
        if (meas_done) begin
          state_nx = last_sub ? DONE : ARMED;
        end else if (start_edge) begin
          state_nx = COUNT;
        end
      end
      COUNT: begin
        if (meas_done) begin
          state_nx = last_sub ? DONE : ARMED;
        end
      end
      DONE: begin
        if (m.m_ready) begin
          state_nx = arm ? ARMED : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // cnt equals cycles elapsed since the start edge while in COUNT
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nx == COUNT) begin
      cnt <= (state == COUNT) ? cnt + ONE : ONE;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (meas_done && last_sub) begin
      data_q <= fin_data;
      ovf_q  <= fin_ovf;
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    m.m_valid    = (state == DONE);
    m.m_data     = data_q;
    m.m_overflow = ovf_q;
  end

endmodule

// File: tb/tb_countdown_delay_meter.sv
// Randomized scoreboard bench for countdown_delay_meter.
// Reference model derives results from the programmed delay directly.
module tb_countdown_delay_meter;

  localparam int W  = 6;
  localparam int AL = 2;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic arm;
  logic start_in;
  logic stop_in;
  logic busy;

  countdown_delay_meter_if #(.WIDTH(W)) bus ();

  countdown_delay_meter #(
    .WIDTH(W),
    .SYNC_STAGES(2),
    .AVG_LOG2(AL)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .arm(arm),
    .start_in(start_in),
    .stop_in(stop_in),
    .busy(busy),
    .m(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int force_stall = 0;

`ifdef DELAY_METER_AVG_EN
  int sub_sum = 0;
  bit sub_ovf = 1'b0;
  int sub_n = 0;
`endif

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(int d, bit stop_en);
    int v;
    bit o;
    if (!stop_en || d >= MAXV) begin
      v = MAXV;
      o = 1'b1;
    end else begin
      v = d;
      o = 1'b0;
    end
`ifdef DELAY_METER_AVG_EN
    sub_sum += v;
    sub_ovf |= o;
    sub_n++;
    if (sub_n == (1 << AL)) begin
      if (sub_ovf) exp_q.push_back('{data: W'(MAXV), ovf: 1'b1});
      else exp_q.push_back('{data: W'(sub_sum >> AL), ovf: 1'b0});
      sub_sum = 0;
      sub_ovf = 1'b0;
      sub_n = 0;
    end
`else
    exp_q.push_back('{data: W'(v), ovf: o});
`endif
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cyc(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic measure(int d, bit stop_en, bit extra);
    wait_drain();
    cyc(3);
    model_push(d, stop_en);
    start_in = ~start_in;
    if (stop_en) begin
      if (d > 0) cyc(d);
      stop_in = ~stop_in;
      cyc(5);
    end else begin
      cyc(MAXV + 5);
    end
    if (extra) begin
      repeat (3) begin
        stop_in = ~stop_in;
        cyc(2);
      end
      cyc(4);
    end
  endtask

  // Monitor: drives m_ready, pops on each transfer, checks hold stability
  initial begin : monitor
    int stall;
    bit rdy;
    bit held_v;
    exp_t held;
    exp_t e;
    stall = 0;
    held_v = 1'b0;
    held = '0;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (held_v) begin
        check("hold_valid", 32'(bus.m_valid), 32'd1);
        check("hold_data", 32'(bus.m_data), 32'(held.data));
        check("hold_ovf", 32'(bus.m_overflow), 32'(held.ovf));
      end
      if (bus.m_valid && !held_v) begin
        if (force_stall != 0) begin
          stall = 20;
          force_stall = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          stall = 20;
        end
      end
      if (stall > 0) begin
        stall--;
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      bus.m_ready = rdy;
      if (bus.m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data=%0d ovf=%0d, required none",
                   bus.m_data, bus.m_overflow);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(bus.m_data), 32'(e.data));
          check("m_overflow", 32'(bus.m_overflow), 32'(e.ovf));
        end
        held_v = 1'b0;
      end else if (bus.m_valid) begin
        held_v = 1'b1;
        held = '{data: bus.m_data, ovf: bus.m_overflow};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    arm = 1'b0;
    start_in = 1'b0;
    stop_in = 1'b0;
    cyc(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_ovf", 32'(bus.m_overflow), 32'd0);
    rst = 1'b0;
    cyc(2);
    check("idle_busy", 32'(busy), 32'd0);
    arm = 1'b1;
    cyc(2);
    check("armed_busy", 32'(busy), 32'd1);

    force_stall = 1;
    measure(37, 1'b1, 1'b1);
    measure(0, 1'b1, 1'b0);
    measure(0, 1'b0, 1'b1);
    measure(MAXV - 1, 1'b1, 1'b0);
    measure(MAXV, 1'b1, 1'b1);
    measure(20, 1'b1, 1'b0);
    measure(1, 1'b1, 1'b1);
    measure(5, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      measure(int'($urandom_range(0, MAXV + 6)),
              $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) == 0);
    end

    wait_drain();
    cyc(3);
    start_in = ~start_in;
    cyc(10);
    check("count_busy", 32'(busy), 32'd1);
    arm = 1'b0;
    rst = 1'b1;
    cyc(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(bus.m_valid), 32'd0);
    rst = 1'b0;
`ifdef DELAY_METER_AVG_EN
    sub_sum = 0;
    sub_ovf = 1'b0;
    sub_n = 0;
`endif
    cyc(5);
    arm = 1'b1;
    cyc(2);
`ifdef DELAY_METER_AVG_EN
    measure(10, 1'b1, 1'b0);
    measure(11, 1'b1, 1'b0);
    measure(12, 1'b1, 1'b0);
    measure(13, 1'b1, 1'b0);
`else
    measure(5, 1'b1, 1'b0);
`endif
    wait_drain();
    cyc(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
